// File: rtl/stage_memory_pkg.sv
// Shared opcodes and state encoding for the memory-access stage.
package stage_memory_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/stage_memory_mem_bus_timer.sv
// Per-access watchdog: cleared on request issue, counts unacknowledged request cycles.
module stage_memory_mem_bus_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] count_q, count_d;

  assign expire = (count_q == CntW'(TIMEOUT - 1));

  // Saturate at the expiry value so the counter never wraps while waiting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stage_memory.sv
// Memory-access pipeline stage with a single-outstanding req/ack bus and access watchdog.
// Define STAGE_MEMORY_ALIGN_CHECK_EN to drop misaligned LW/SW with a misalign_err pulse.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int unsigned BIT_WIDTH       = 32,
  parameter int unsigned REG_INDEX_WIDTH = 4,
  parameter int unsigned TIMEOUT         = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [3:0]                 op_code,
  input  logic [BIT_WIDTH-1:0]       alu_out,
  input  logic [BIT_WIDTH-1:0]       store_data,
  input  logic [REG_INDEX_WIDTH-1:0] dst_reg,
  input  logic                       reg_wr,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [BIT_WIDTH-1:0]       mem_addr,
  output logic [BIT_WIDTH-1:0]       mem_wdata,
  input  logic [BIT_WIDTH-1:0]       mem_rdata,
  input  logic                       mem_ack,
  output logic                       wb_en,
  output logic [REG_INDEX_WIDTH-1:0] wb_reg,
  output logic [BIT_WIDTH-1:0]       wb_data,
  output logic                       bus_err,
  output logic                       misalign_err
);

  state_e state_q, state_d;

  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [BIT_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [BIT_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic                       wb_en_q, wb_en_d;
  logic [REG_INDEX_WIDTH-1:0] wb_reg_q, wb_reg_d;
  logic [BIT_WIDTH-1:0]       wb_data_q, wb_data_d;
  logic                       bus_err_q, bus_err_d;
  logic                       misalign_err_q, misalign_err_d;
  logic [REG_INDEX_WIDTH-1:0] ld_reg_q, ld_reg_d;

  logic                 is_mem;
  logic                 misaligned;
  logic [BIT_WIDTH-1:0] issue_addr;
  logic                 stall_raw;
  logic                 timer_clear;
  logic                 timer_enable;
  logic                 timer_expire;

  assign is_mem = is_mem_op(op_code);

`ifdef STAGE_MEMORY_ALIGN_CHECK_EN
  assign misaligned = (alu_out[1:0] != 2'b00);
  assign issue_addr = alu_out;
`else
  assign misaligned = 1'b0;
  assign issue_addr = {alu_out[BIT_WIDTH-1:2], 2'b00};
`endif

  stage_memory_mem_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid && is_mem && !misaligned) state_d = StReq;
      StReq:   if (mem_ack || timer_expire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    wb_en_d        = 1'b0;
    wb_reg_d       = wb_reg_q;
    wb_data_d      = wb_data_q;
    bus_err_d      = 1'b0;
    misalign_err_d = 1'b0;
    ld_reg_d       = ld_reg_q;
    stall_raw      = 1'b0;
    timer_clear    = 1'b0;
    timer_enable   = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_en_d   = reg_wr;
            wb_reg_d  = dst_reg;
            wb_data_d = alu_out;
          end else if (misaligned) begin
            misalign_err_d = 1'b1;
          end else begin
            stall_raw   = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = (op_code == OP_SW);
            mem_addr_d  = issue_addr;
            mem_wdata_d = store_data;
            ld_reg_d    = dst_reg;
            timer_clear = 1'b1;
          end
        end
      end
      StReq: begin
        // Ack takes priority over a coincident watchdog expiry.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = ld_reg_q;
            wb_data_d = mem_rdata;
          end
        end else if (timer_expire) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          stall_raw    = 1'b1;
          timer_enable = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      wb_en_q        <= 1'b0;
      wb_reg_q       <= '0;
      wb_data_q      <= '0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
      ld_reg_q       <= '0;
    end else begin
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      wb_en_q        <= wb_en_d;
      wb_reg_q       <= wb_reg_d;
      wb_data_q      <= wb_data_d;
      bus_err_q      <= bus_err_d;
      misalign_err_q <= misalign_err_d;
      ld_reg_q       <= ld_reg_d;
    end
  end

  assign stall        = reset_n && stall_raw;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_en        = wb_en_q;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_q;
  assign bus_err      = bus_err_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for stage_memory: writebacks queued at issue, popped when wb_en fires.
module tb_stage_memory;
  import stage_memory_pkg::*;

  localparam int unsigned BW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [3:0]    op_code;
  logic [BW-1:0] alu_out;
  logic [BW-1:0] store_data;
  logic [RW-1:0] dst_reg;
  logic          reg_wr;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata;
  logic          mem_ack;
  logic          wb_en;
  logic [RW-1:0] wb_reg;
  logic [BW-1:0] wb_data;
  logic          bus_err;
  logic          misalign_err;

  always #5 clk = ~clk;

  stage_memory #(
    .BIT_WIDTH      (BW),
    .REG_INDEX_WIDTH(RW),
    .TIMEOUT        (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .op_code     (op_code),
    .alu_out     (alu_out),
    .store_data  (store_data),
    .dst_reg     (dst_reg),
    .reg_wr      (reg_wr),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .bus_err     (bus_err),
    .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic [RW-1:0] rg;
    logic [BW-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  bus_err_seen = 0;
  int  misalign_seen = 0;
  int  exp_bus_err = 0;
  int  exp_misalign = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wb_t e;
    if (reset_n) begin
      if (bus_err) bus_err_seen++;
      if (misalign_err) misalign_seen++;
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          check_eq("wb_unexpected", 32'(wb_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("wb_reg", 32'(wb_reg), 32'(e.rg));
          check_eq("wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nonmem(input logic [3:0] op, input logic [BW-1:0] alu, input logic [RW-1:0] dst,
                        input logic rw);
    wb_t w;
    in_valid = 1'b1;
    op_code  = op;
    alu_out  = alu;
    dst_reg  = dst;
    reg_wr   = rw;
    #1;
    check_eq("nm_stall", 32'(stall), 32'd0);
    if (rw) begin
      w.rg   = dst;
      w.data = alu;
      exp_q.push_back(w);
    end
    step();
    in_valid = 1'b0;
  endtask

  // k = REQ cycle on which ack is given; 0 means never (watchdog expiry).
  task automatic mem_op(input logic [3:0] op, input logic [BW-1:0] addr, input logic [BW-1:0] sdata,
                        input logic [RW-1:0] dst, input int k, input logic [BW-1:0] rdata);
    wb_t           w;
    logic          is_sw;
    logic [BW-1:0] exp_addr;
    int            req_cycles;
    int            stall_cycles;
    int            held_bad;
    is_sw        = (op == OP_SW);
    exp_addr     = addr & ~32'h3;
    req_cycles   = 0;
    stall_cycles = 0;
    held_bad     = 0;
    in_valid     = 1'b1;
    op_code      = op;
    alu_out      = addr;
    store_data   = sdata;
    dst_reg      = dst;
    reg_wr       = !is_sw;
    #1;
    if (stall) stall_cycles++;
    step();
    in_valid   = 1'b0;
    op_code    = OP_ADD;
    alu_out    = 32'hFFFF_FFFF;
    store_data = 32'hFFFF_FFFF;
    check_eq("req_addr", mem_addr, exp_addr);
    check_eq("req_we", 32'(mem_we), 32'(is_sw));
    if (is_sw) check_eq("req_wdata", mem_wdata, sdata);
    for (int i = 1; i <= int'(TO); i++) begin
      if (mem_req) req_cycles++;
      if (mem_addr !== exp_addr || mem_we !== is_sw || (is_sw && mem_wdata !== sdata)) held_bad++;
      if (i == k) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        if (!is_sw) begin
          w.rg   = dst;
          w.data = rdata;
          exp_q.push_back(w);
        end
      end
      #1;
      if (stall) stall_cycles++;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if (i == k) break;
    end
    check_eq("req_cycles", 32'(req_cycles), (k == 0) ? TO : 32'(k));
    check_eq("stall_cycles", 32'(stall_cycles), (k == 0) ? TO : 32'(k));
    check_eq("req_held", 32'(held_bad), 32'd0);
    check_eq("req_drop", 32'(mem_req), 32'd0);
    check_eq("bus_err", 32'(bus_err), (k == 0) ? 32'd1 : 32'd0);
    if (k == 0) exp_bus_err++;
    step();
    check_eq("bus_err_pulse", 32'(bus_err), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    op_code    = OP_ADD;
    alu_out    = '0;
    store_data = '0;
    dst_reg    = '0;
    reg_wr     = 1'b0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    step();
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_wb_en", 32'(wb_en), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_bus_err", 32'(bus_err), 32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    nonmem(OP_ADD, 32'h0000_0042, 4'd3, 1'b1);
    nonmem(OP_SUB, 32'h0000_0777, 4'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nonmem(OP_SUB, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    end
    step();
    check_eq("idle_wb_en", 32'(wb_en), 32'd0);

    // Stray ack while idle must do nothing.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("idle_ack_req", 32'(mem_req), 32'd0);
    check_eq("idle_ack_wb", 32'(wb_en), 32'd0);

    mem_op(OP_LW, 32'h0000_0100, 32'h0, 4'd5, 3, 32'hDEAD_BEEF);
    mem_op(OP_SW, 32'h0000_0104, 32'h0000_1234, 4'd6, 2, 32'hAAAA_5555);
    mem_op(OP_LW, 32'h0000_0108, 32'h0, 4'd2, 0, 32'h0);
    mem_op(OP_LW, 32'h0000_010C, 32'h0, 4'd9, int'(TO), 32'hCAFE_F00D);
    mem_op(OP_LW, 32'h0000_0110, 32'h0, 4'd1, 1, 32'h1111_2222);

    // Reset in the middle of an access.
    in_valid = 1'b1;
    op_code  = OP_LW;
    alu_out  = 32'h0000_0200;
    dst_reg  = 4'd4;
    reg_wr   = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("mid_req", 32'(mem_req), 32'd1);
    in_valid = 1'b1;
    reset_n  = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(mem_req), 32'd0);
    check_eq("mid_rst_wb", 32'(wb_en), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    in_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    check_eq("post_rst_req", 32'(mem_req), 32'd0);
    mem_op(OP_LW, 32'h0000_0300, 32'h0, 4'd8, 2, 32'h0BAD_F00D);

`ifdef STAGE_MEMORY_ALIGN_CHECK_EN
    in_valid = 1'b1;
    op_code  = OP_LW;
    alu_out  = 32'h0000_0102;
    dst_reg  = 4'd3;
    reg_wr   = 1'b1;
    #1;
    check_eq("mis_stall", 32'(stall), 32'd0);
    step();
    in_valid = 1'b0;
    check_eq("mis_req", 32'(mem_req), 32'd0);
    check_eq("mis_err", 32'(misalign_err), 32'd1);
    check_eq("mis_wb", 32'(wb_en), 32'd0);
    exp_misalign++;
    step();
    check_eq("mis_err_pulse", 32'(misalign_err), 32'd0);
`else
    mem_op(OP_LW, 32'h0000_0102, 32'h0, 4'd3, 2, 32'h5A5A_A5A5);
`endif

    step();
    step();
    check_eq("bus_err_count", 32'(bus_err_seen), 32'(exp_bus_err));
    check_eq("misalign_count", 32'(misalign_seen), 32'(exp_misalign));
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
